lut_sweep_eval: RTL and testbench

- Parametrised truth-table evaluator for the boolean-function exercise blocks.
- Holds N_FUNCS programmable functions of N_VARS inputs, each stored as a 2^N_VARS-bit lookup table.
- On command, sweeps every input combination from 0 to 2^N_VARS-1 and presents each input vector with all function outputs.
- Sits between a config/host interface and a display/checker. Replaces hand-written per-function combinational modules and delay-driven stimulus.

---
 rtl/lut_sweep_eval.sv | 160 ++++++++++++++++
 tb/tb_lut_sweep_eval.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_eval.sv
// Truth-table evaluator: N_FUNCS programmable LUTs swept over every input combination.
// Define LUT_SWEEP_CHECK_EN to add an expected-value bank with a saturating mismatch counter.
module lut_sweep_eval #(
  parameter  int N_VARS  = 3,
  parameter  int N_FUNCS = 5,
  parameter  int HOLD    = 1,
  localparam int FW      = (N_FUNCS > 1) ? $clog2(N_FUNCS) : 1,
  localparam int D       = 1 << N_VARS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [FW-1:0]      cfg_func,
  input  logic [D-1:0]       cfg_data,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic [N_VARS-1:0]  in_vec,
  output logic [N_FUNCS-1:0] out_vec,
  output logic               out_valid,
  output logic               done
`ifdef LUT_SWEEP_CHECK_EN
  ,
  input  logic               cfg_exp,
  output logic [N_VARS:0]    err_cnt,
  output logic               err_any
`endif
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [D-1:0]       lut_q [N_FUNCS];
  logic [N_VARS-1:0]  in_vec_q, in_vec_d, sel_idx;
  logic [N_FUNCS-1:0] out_vec_q, out_vec_d, load_vec;
  logic [HW-1:0]      hold_q, hold_d, hold_eff;
  logic               out_valid_q, out_valid_d;
  logic               go, wr_en, wr_lut;

  assign go    = (state_q == IDLE) && start && !stop;
  assign wr_en = cfg_we && (state_q == IDLE) && (int'(cfg_func) < N_FUNCS);
`ifdef LUT_SWEEP_CHECK_EN
  assign wr_lut = wr_en && !cfg_exp;
`else
  assign wr_lut = wr_en;
`endif

  // Column of function outputs for the index about to be shown; a same-cycle write wins.
  always_comb begin
    sel_idx  = (state_q == RUN) ? in_vec_q + 1'b1 : '0;
    load_vec = '0;
    for (int f = 0; f < N_FUNCS; f++) begin
      if (wr_lut && int'(cfg_func) == f) load_vec[f] = cfg_data[sel_idx];
      else                               load_vec[f] = lut_q[f][sel_idx];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    in_vec_d    = in_vec_q;
    out_vec_d   = out_vec_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    // The edge right after a strobe is the first hold cycle of the next index.
    hold_eff    = out_valid_q ? '0 : hold_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = RUN;
          in_vec_d  = '0;
          out_vec_d = load_vec;
          hold_d    = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (out_valid_q && (in_vec_q == '1)) begin
          state_d = FIN;
          hold_d  = '0;
        end else begin
          if (out_valid_q) begin
            in_vec_d  = sel_idx;
            out_vec_d = load_vec;
          end
          if (hold_eff == HW'(HOLD - 1)) begin
            out_valid_d = 1'b1;
            hold_d      = '0;
          end else begin
            hold_d = hold_eff + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the LUT array is reset explicitly because reset must erase the programmed functions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < N_FUNCS; f++) lut_q[f] <= '0;
      in_vec_q    <= '0;
      out_vec_q   <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int f = 0; f < N_FUNCS; f++)
        if (wr_lut && int'(cfg_func) == f) lut_q[f] <= cfg_data;
      in_vec_q    <= in_vec_d;
      out_vec_q   <= out_vec_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign in_vec    = in_vec_q;
  assign out_vec   = out_vec_q;
  assign out_valid = out_valid_q;

`ifdef LUT_SWEEP_CHECK_EN
  logic [D-1:0]  exp_q [N_FUNCS];
  logic [N_VARS:0] err_q;
  logic          mismatch;

  always_comb begin
    mismatch = 1'b0;
    for (int f = 0; f < N_FUNCS; f++)
      if (out_vec_q[f] != exp_q[f][in_vec_q]) mismatch = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < N_FUNCS; f++) exp_q[f] <= '0;
      err_q <= '0;
    end else begin
      for (int f = 0; f < N_FUNCS; f++)
        if (wr_en && cfg_exp && int'(cfg_func) == f) exp_q[f] <= cfg_data;
      if (go)                                            err_q <= '0;
      else if (out_valid_q && mismatch && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
  assign err_any = (err_q != '0);
`endif

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench for lut_sweep_eval: time-based sweep model plus directed literal checks.
`timescale 1ns/1ps
module tb_lut_sweep_eval;
  localparam int NV = 3;
  localparam int NF = 5;
  localparam int H  = 1;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic reset;
  logic cfg_we, start, stop;
  logic [2:0] cfg_func;
  logic [7:0] cfg_data;
  logic busy, out_valid, done;
  logic [2:0] in_vec;
  logic [4:0] out_vec;

  logic start2;
  logic cfg_we2 = 1'b0;
  logic [2:0] cfg_func2 = 3'd0;
  logic [3:0] cfg_data2 = 4'd0;
  logic stop2 = 1'b0;
  logic busy2, ov2, done2;
  logic [1:0] in2;
  logic [4:0] out2;

`ifdef LUT_SWEEP_CHECK_EN
  logic cfg_exp;
  logic [3:0] err_cnt;
  logic err_any;
  logic cfg_exp2 = 1'b0;
  logic [2:0] err_cnt2;
  logic err_any2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe = 0, n_done = 0, last_strobe = 0, done_cyc = 0;
  logic [4:0] seen [D];
  logic h_fin = 1'b0;
  int h_strobes[$];
  int h_done_at = -1;

  lut_sweep_eval dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_func(cfg_func), .cfg_data(cfg_data),
    .start(start), .stop(stop), .busy(busy), .in_vec(in_vec), .out_vec(out_vec),
    .out_valid(out_valid), .done(done)
`ifdef LUT_SWEEP_CHECK_EN
    , .cfg_exp(cfg_exp), .err_cnt(err_cnt), .err_any(err_any)
`endif
  );

  lut_sweep_eval #(.N_VARS(2), .N_FUNCS(5), .HOLD(3)) dut_h3 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we2), .cfg_func(cfg_func2), .cfg_data(cfg_data2),
    .start(start2), .stop(stop2), .busy(busy2), .in_vec(in2), .out_vec(out2),
    .out_valid(ov2), .done(done2)
`ifdef LUT_SWEEP_CHECK_EN
    , .cfg_exp(cfg_exp2), .err_cnt(err_cnt2), .err_any(err_any2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural model: outputs derived from cycles elapsed since the accepted start.
  logic [D-1:0]  m_lut [NF];
  logic          m_active, m_valid, m_done, fin_now;
  logic [NV-1:0] m_vec;
  logic [NF-1:0] m_out;
  int            m_t;
`ifdef LUT_SWEEP_CHECK_EN
  logic [D-1:0]  m_exp [NF];
  logic [NV:0]   m_err;
`endif

  function automatic logic [NF-1:0] col_lut(input logic [NV-1:0] i);
    logic [NF-1:0] r;
    for (int f = 0; f < NF; f++) r[f] = m_lut[f][i];
    return r;
  endfunction

`ifdef LUT_SWEEP_CHECK_EN
  function automatic logic [NF-1:0] col_exp(input logic [NV-1:0] i);
    logic [NF-1:0] r;
    for (int f = 0; f < NF; f++) r[f] = m_exp[f][i];
    return r;
  endfunction
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < NF; f++) m_lut[f] = '0;
      m_active = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_vec = '0; m_out = '0; m_t = 0;
`ifdef LUT_SWEEP_CHECK_EN
      for (int f = 0; f < NF; f++) m_exp[f] = '0;
      m_err = '0;
`endif
    end else begin
`ifdef LUT_SWEEP_CHECK_EN
      if (m_valid && (m_out != col_exp(m_vec)) && (m_err != '1)) m_err = m_err + 1'b1;
`endif
      fin_now = m_done;
      m_done  = 1'b0;
      if (m_active) begin
        if (stop) begin
          m_active = 1'b0;
          m_valid  = 1'b0;
        end else begin
          m_t = m_t + 1;
          if (m_t > D * H) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_done   = 1'b1;
          end else begin
            m_vec   = NV'((m_t - 1) / H);
            m_out   = col_lut(m_vec);
            m_valid = (m_t % H == 0);
          end
        end
      end else if (!fin_now) begin
        if (cfg_we && int'(cfg_func) < NF) begin
`ifdef LUT_SWEEP_CHECK_EN
          if (cfg_exp) m_exp[cfg_func] = cfg_data;
          else         m_lut[cfg_func] = cfg_data;
`else
          m_lut[cfg_func] = cfg_data;
`endif
        end
        if (start && !stop) begin
          m_active = 1'b1; m_t = 0; m_vec = '0; m_out = col_lut('0); m_valid = 1'b0;
`ifdef LUT_SWEEP_CHECK_EN
          m_err = '0;
`endif
        end
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("cycle_outputs", {busy, done, out_valid, in_vec, out_vec},
            {m_active, m_done, m_valid, m_vec, m_out});
`ifdef LUT_SWEEP_CHECK_EN
      check("cycle_err", {err_any, err_cnt}, {(m_err != '0), m_err});
`endif
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        n_strobe    <= n_strobe + 1;
        seen[in_vec] <= out_vec;
        last_strobe <= cyc;
      end
      if (done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic cfg(input int f, input logic [7:0] d);
    cfg_we = 1'b1; cfg_func = 3'(f); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

`ifdef LUT_SWEEP_CHECK_EN
  task automatic cfg_x(input int f, input logic [7:0] d);
    cfg_exp = 1'b1;
    cfg(f, d);
    cfg_exp = 1'b0;
  endtask
`endif

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) check("idle_timeout", busy, 1'b0);
  endtask

  task automatic sweep();
    go();
    wait_idle();
    @(negedge clk);
  endtask

  initial begin : hold_test
    start2 = 1'b0;
    @(negedge clk);
    while (reset) @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov2) h_strobes.push_back(e);
      if (done2 && h_done_at < 0) h_done_at = e;
    end
    check("h3_strobe_count", h_strobes.size(), 4);
    for (int i = 0; i < 4; i++)
      check("h3_strobe_edge", (i < h_strobes.size()) ? h_strobes[i] : -1, 3 * (i + 1));
    check("h3_done_edge", h_done_at, 13);
    check("h3_busy_end", busy2, 1'b0);
    h_fin = 1'b1;
  end

  initial begin : main
    int b, bd, n;
    reset = 1'b1; cfg_we = 1'b0; cfg_func = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
`ifdef LUT_SWEEP_CHECK_EN
    cfg_exp = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, out_valid, in_vec, out_vec}, '0);
`ifdef LUT_SWEEP_CHECK_EN
    check("reset_err", {err_any, err_cnt}, '0);
`endif
    reset = 1'b0;
    @(negedge clk);

    b = n_strobe; bd = n_done;
    sweep();
    check("zero_strobes", n_strobe - b, 8);
    check("zero_done_pulses", n_done - bd, 1);
    check("done_after_last", done_cyc - last_strobe, 1);
    check("zero_busy_after", busy, 1'b0);
    check("zero_retain_vec", in_vec, 3'd7);

    cfg(0, 8'b00000100); cfg(1, 8'b01000000); cfg(2, 8'b00000011);
    cfg(3, 8'b10101010); cfg(4, 8'b00000100);
    cfg(5, 8'hFF); cfg(7, 8'hFF);
    sweep();
    check("lut_vec0", seen[0], 5'b00100);
    check("lut_vec2", seen[2], 5'b10001);
    check("lut_vec6", seen[6], 5'b00010);
    check("lut_vec7", seen[7], 5'b01000);

    cfg_we = 1'b1; cfg_func = 3'd4; cfg_data = 8'b00000001; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    check("write_first_vec", out_vec, 5'b10100);
    wait_idle();
    @(negedge clk);
    check("write_first_seen", seen[0], 5'b10100);
    cfg(4, 8'b00000100);

`ifdef LUT_SWEEP_CHECK_EN
    cfg_x(0, 8'b00001100); cfg_x(1, 8'b01000000); cfg_x(2, 8'b00000011);
    cfg_x(3, 8'b10101010); cfg_x(4, 8'b00000100);
    sweep();
    check("err_cnt_after_done", err_cnt, 4'd1);
    check("err_any_after_done", err_any, 1'b1);
`endif

    go();
    n = 0;
    while (in_vec != 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stop_reach4", in_vec, 3'd4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 1'b0);
    check("stop_vec", in_vec, 3'd4);
    @(negedge clk);
    b = n_strobe; bd = n_done;
    repeat (12) @(negedge clk);
    check("stop_no_strobe", n_strobe - b, 0);
    check("stop_no_done", n_done - bd, 0);
    check("stop_hold_vec", in_vec, 3'd4);
    go();
    check("restart_vec", in_vec, 3'd0);
    check("restart_busy", busy, 1'b1);
    wait_idle();

    go();
    repeat (2) @(negedge clk);
    cfg_we = 1'b1; cfg_func = 3'd0; cfg_data = 8'hFF; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle();
    sweep();
    check("run_ignore_lut0", seen[0], 5'b00100);
    check("run_ignore_lut2", seen[2], 5'b10001);

    for (int i = 0; i < 400; i++) begin
      cfg_we   = ($urandom_range(3) == 0);
      cfg_func = 3'($urandom_range(7));
      cfg_data = 8'($urandom);
      start    = ($urandom_range(5) == 0);
      stop     = ($urandom_range(24) == 0);
`ifdef LUT_SWEEP_CHECK_EN
      cfg_exp  = 1'($urandom);
`endif
      @(negedge clk);
    end
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef LUT_SWEEP_CHECK_EN
    cfg_exp = 1'b0;
`endif
    @(negedge clk);
    wait_idle();

    go();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_outputs", {busy, done, out_valid, in_vec, out_vec}, '0);
`ifdef LUT_SWEEP_CHECK_EN
    check("mid_reset_err", {err_any, err_cnt}, '0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    b = n_done;
    sweep();
    check("post_reset_done", n_done - b, 1);
    check("post_reset_vec2", seen[2], 5'b00000);
    check("post_reset_vec7", seen[7], 5'b00000);

    n = 0;
    while (!h_fin && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!h_fin) check("hold_test_timeout", h_fin, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
